// File: rtl/demux_sched_pkg.sv
// Shared definitions for the demux scheduler slice.
//   LANES      : number of consumer lanes behind the 1-to-8 demux
//   SEL_W      : width of the binary lane index driven to the demux
//   state_e    : scheduler FSM states
//   hold_cnt_w : width of the hold-window down-counter for a given HOLD_CYCLES
package demux_sched_pkg;

  localparam int unsigned LANES = 8;
  localparam int unsigned SEL_W = 3;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_DATA = 2'd1,
    HOLD      = 2'd2,
    ACK       = 2'd3
  } state_e;

  // Counter must represent HOLD_CYCLES-1 down to 0; one extra code keeps
  // HOLD_CYCLES=1 at a legal 1-bit width.
  function automatic int hold_cnt_w(input int hold_cycles);
    return $clog2(hold_cycles + 1);
  endfunction

endpackage

// File: rtl/rr_arbiter8.sv
// Combinational 8-lane round-robin arbiter.
//   req       : per-lane request vector, bit i = lane i
//   ptr       : index of the lane granted last
//   gnt_idx   : first requesting lane found scanning ptr+1, ptr+2, ... mod 8
//   gnt_valid : at least one lane is requesting (gnt_idx meaningful)
module rr_arbiter8
  import demux_sched_pkg::*;
(
  input  logic [LANES-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] gnt_idx,
  output logic             gnt_valid
);

  logic [LANES-1:0] rot_s;
  logic [SEL_W-1:0] off_s;

  // Rotate requests so bit 0 is the lane right after the last grant.
  always_comb begin
    rot_s = 8'h00;
    for (int i = 0; i < LANES; i++) begin
      rot_s[i] = req[ptr + 3'd1 + 3'(i)];
    end
  end

  // Lowest set bit of the rotated vector is the distance from ptr+1.
  always_comb begin
    off_s = 3'd0;
    casez (rot_s)
      8'b???????1: off_s = 3'd0;
      8'b??????10: off_s = 3'd1;
      8'b?????100: off_s = 3'd2;
      8'b????1000: off_s = 3'd3;
      8'b???10000: off_s = 3'd4;
      8'b??100000: off_s = 3'd5;
      8'b?1000000: off_s = 3'd6;
      8'b10000000: off_s = 3'd7;
      default:     off_s = 3'd0;
    endcase
  end

  // Map the offset back to an absolute lane index (3-bit wrap).
  always_comb begin
    gnt_idx   = ptr + 3'd1 + off_s;
    gnt_valid = |req;
  end

endmodule

// File: rtl/demux_scheduler.sv
// Round-robin scheduler sharing one serial source among 8 demux lanes.
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   req        : per-lane level request
//   in_valid/in_data/in_ready : source word handshake (transfer on valid & ready)
//   sel        : binary lane index to the demux (sel[2]->s0, sel[1]->s1, sel[0]->s2)
//   dout       : data to demux din, dout_en high while it is delivered
//   ack        : one-hot, one-cycle completion pulse to the served lane
//   busy       : high whenever the scheduler is not idle
// Every output comes straight from a register.
module demux_scheduler
  import demux_sched_pkg::*;
#(
  parameter int unsigned DATA_W      = 1,
  parameter int unsigned HOLD_CYCLES = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [LANES-1:0]  req,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [SEL_W-1:0]  sel,
  output logic [DATA_W-1:0] dout,
  output logic              dout_en,
  output logic [LANES-1:0]  ack,
  output logic              busy
);

  localparam int CNT_W = hold_cnt_w(HOLD_CYCLES);

  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("demux_scheduler: HOLD_CYCLES must be >= 1");
  end

  state_e            state_r;
  state_e            state_n_s;
  logic [SEL_W-1:0]  ptr_r;
  logic [SEL_W-1:0]  grant_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [SEL_W-1:0]  sel_r;
  logic [DATA_W-1:0] dout_r;
  logic              dout_en_r;
  logic [LANES-1:0]  ack_r;
  logic              in_ready_r;
  logic              busy_r;
  logic [SEL_W-1:0]  gnt_idx_s;
  logic              gnt_valid_s;

  rr_arbiter8 u_arb (
    .req       (req),
    .ptr       (ptr_r),
    .gnt_idx   (gnt_idx_s),
    .gnt_valid (gnt_valid_s)
  );

  // Next-state selection; a handshake takes priority over a dropped request.
  always_comb begin
    state_n_s = state_r;
    case (state_r)
      IDLE: begin
        if (gnt_valid_s) begin
          state_n_s = WAIT_DATA;
        end else begin
          state_n_s = IDLE;
        end
      end
      WAIT_DATA: begin
        if (in_valid) begin
          state_n_s = HOLD;
        end else if (!req[grant_r]) begin
          state_n_s = IDLE;
        end else begin
          state_n_s = WAIT_DATA;
        end
      end
      HOLD: begin
        if (cnt_r == CNT_W'(0)) begin
          state_n_s = ACK;
        end else begin
          state_n_s = HOLD;
        end
      end
      ACK:     state_n_s = IDLE;
      default: state_n_s = IDLE;
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      ptr_r      <= 3'd7;
      grant_r    <= 3'd0;
      cnt_r      <= CNT_W'(0);
      sel_r      <= 3'd0;
      dout_r     <= DATA_W'(0);
      dout_en_r  <= 1'b0;
      ack_r      <= 8'h00;
      in_ready_r <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_n_s;
      // Ready and busy track the state being entered so they line up with it.
      in_ready_r <= (state_n_s == WAIT_DATA);
      busy_r     <= (state_n_s != IDLE);
      case (state_r)
        IDLE: begin
          if (gnt_valid_s) begin
            grant_r <= gnt_idx_s;
          end else begin
            grant_r <= grant_r;
          end
        end
        WAIT_DATA: begin
          if (in_valid) begin
            dout_r    <= in_data;
            sel_r     <= grant_r;
            dout_en_r <= 1'b1;
            cnt_r     <= CNT_W'(HOLD_CYCLES - 1);
          end else begin
            dout_en_r <= 1'b0;
          end
        end
        HOLD: begin
          if (cnt_r == CNT_W'(0)) begin
            // Leaving the hold window: clear demux data, pulse ack, advance ptr.
            dout_en_r <= 1'b0;
            dout_r    <= DATA_W'(0);
            ack_r     <= 8'b0000_0001 << grant_r;
            ptr_r     <= grant_r;
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        ACK: begin
          ack_r <= 8'h00;
        end
        default: begin
          ack_r     <= 8'h00;
          dout_en_r <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready = in_ready_r;
  assign sel      = sel_r;
  assign dout     = dout_r;
  assign dout_en  = dout_en_r;
  assign ack      = ack_r;
  assign busy     = busy_r;

endmodule

// File: tb/tb_demux_scheduler.sv
// Self-checking bench for demux_scheduler (DATA_W=1, HOLD_CYCLES=3).
module tb_demux_scheduler;

  localparam int H = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req = 8'h00;
  logic       in_valid = 1'b0;
  logic [0:0] in_data = 1'b0;
  logic       in_ready;
  logic [2:0] sel;
  logic [0:0] dout;
  logic       dout_en;
  logic [7:0] ack;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  demux_scheduler #(.DATA_W(1), .HOLD_CYCLES(H)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .sel      (sel),
    .dout     (dout),
    .dout_en  (dout_en),
    .ack      (ack),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // ---------------- transaction-level reference model ----------------
  int         m_ptr;
  bit         m_active;
  bit         m_have_word;
  int         m_lane;
  int         m_hold_left;
  logic       e_rdy, e_en, e_dout, e_busy;
  logic [2:0] e_sel;
  logic [7:0] e_ack;

  task automatic model_reset();
    m_ptr = 7; m_active = 0; m_have_word = 0; m_lane = 0; m_hold_left = 0;
    e_rdy = 0; e_en = 0; e_dout = 0; e_busy = 0; e_sel = 3'd0; e_ack = 8'h00;
  endtask

  // Advance the model by one clock edge using the inputs seen at that edge.
  task automatic model_step();
    bit found;
    if (e_ack != 8'h00) begin
      e_ack = 8'h00; e_busy = 0;
    end else if (!m_active) begin
      found = 0;
      for (int k = 1; k <= 8; k++) begin
        int l;
        l = (m_ptr + k) % 8;
        if (!found && req[l]) begin
          found = 1; m_lane = l;
        end
      end
      if (found) begin
        m_active = 1; m_have_word = 0; e_rdy = 1; e_busy = 1;
      end
    end else if (!m_have_word) begin
      if (in_valid) begin
        m_have_word = 1; m_hold_left = H;
        e_dout = in_data[0]; e_sel = 3'(m_lane); e_en = 1; e_rdy = 0;
      end else if (!req[m_lane]) begin
        m_active = 0; e_rdy = 0; e_busy = 0;
      end
    end else begin
      m_hold_left--;
      if (m_hold_left == 0) begin
        e_en = 0; e_dout = 0; e_ack = 8'h01 << m_lane; m_ptr = m_lane; m_active = 0;
      end
    end
  endtask

  function automatic logic [7:0] demux_d();
    return dout_en ? (8'(dout) << sel) : 8'h00;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  task automatic compare_model();
    check("in_ready", 32'(in_ready), 32'(e_rdy));
    check("dout_en",  32'(dout_en),  32'(e_en));
    check("dout",     32'(dout),     32'(e_dout));
    check("sel",      32'(sel),      32'(e_sel));
    check("ack",      32'(ack),      32'(e_ack));
    check("busy",     32'(busy),     32'(e_busy));
  endtask

  task automatic step(input bit cmp);
    @(posedge clk);
    cyc++;
    model_step();
    @(negedge clk);
    if (cmp) compare_model();
  endtask

  // Step until an ack appears (bounded); the ack seen must be the expected one.
  task automatic wait_ack(input logic [7:0] exp, input string name);
    int n;
    n = 0;
    do begin
      step(1'b1);
      n++;
    end while (ack == 8'h00 && n < 30);
    check(name, 32'(ack), 32'(exp));
  endtask

  typedef struct {
    logic [7:0] req;
    logic       vld;
    logic       dat;
    logic       e_rdy;
    logic       e_en;
    logic [2:0] e_sel;
    logic       e_dout;
    logic [7:0] e_ack;
    logic       e_busy;
    logic [7:0] e_d;
  } vec_t;

  vec_t tbl [7];

  initial begin
    int t_prev;
    bit en_seen;

    //            req    v  d  rdy en sel  do ack    busy d
    tbl[0] = '{8'h20, 1, 1, 1, 0, 3'd0, 0, 8'h00, 1, 8'h00};
    tbl[1] = '{8'h20, 1, 1, 0, 1, 3'd5, 1, 8'h00, 1, 8'h20};
    tbl[2] = '{8'h20, 1, 1, 0, 1, 3'd5, 1, 8'h00, 1, 8'h20};
    tbl[3] = '{8'h20, 1, 1, 0, 1, 3'd5, 1, 8'h00, 1, 8'h20};
    tbl[4] = '{8'h20, 1, 1, 0, 0, 3'd5, 0, 8'h20, 1, 8'h00};
    tbl[5] = '{8'h00, 0, 0, 0, 0, 3'd5, 0, 8'h00, 0, 8'h00};
    tbl[6] = '{8'h00, 0, 0, 0, 0, 3'd5, 0, 8'h00, 0, 8'h00};

    model_reset();
    repeat (2) @(negedge clk);
    check("rst_busy",    32'(busy),     32'd0);
    check("rst_in_ready",32'(in_ready), 32'd0);
    check("rst_dout_en", 32'(dout_en),  32'd0);
    check("rst_ack",     32'(ack),      32'd0);
    check("rst_sel",     32'(sel),      32'd0);
    rst_n = 1'b1;

    // Single-lane transfer, cycle by cycle.
    for (int i = 0; i < 7; i++) begin
      req = tbl[i].req; in_valid = tbl[i].vld; in_data = tbl[i].dat;
      step(1'b0);
      check($sformatf("tbl%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].e_rdy));
      check($sformatf("tbl%0d_dout_en", i),  32'(dout_en),  32'(tbl[i].e_en));
      check($sformatf("tbl%0d_sel", i),      32'(sel),      32'(tbl[i].e_sel));
      check($sformatf("tbl%0d_dout", i),     32'(dout),     32'(tbl[i].e_dout));
      check($sformatf("tbl%0d_ack", i),      32'(ack),      32'(tbl[i].e_ack));
      check($sformatf("tbl%0d_busy", i),     32'(busy),     32'(tbl[i].e_busy));
      check($sformatf("tbl%0d_demux", i),    32'(demux_d()),32'(tbl[i].e_d));
    end

    // Reset during HOLD: everything clears at once, no ack.
    req = 8'h10; in_valid = 1'b1; in_data = 1'b1;
    repeat (3) step(1'b1);
    check("pre_rst_dout_en", 32'(dout_en), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_dout_en", 32'(dout_en), 32'd0);
    check("midrst_dout",    32'(dout),    32'd0);
    check("midrst_sel",     32'(sel),     32'd0);
    check("midrst_ack",     32'(ack),     32'd0);
    check("midrst_busy",    32'(busy),    32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1; req = 8'hFF; in_valid = 1'b1; in_data = 1'b1;

    // Fairness: all lanes requesting, lanes 0..7 then 0 again, 6-cycle period.
    t_prev = 0;
    for (int n = 0; n < 9; n++) begin
      wait_ack(8'h01 << (n % 8), $sformatf("fair_lane%0d", n % 8));
      if (n > 0) check("fair_period", 32'(cyc - t_prev), 32'(H + 3));
      t_prev = cyc;
    end

    // Pointer wrap: after lane 2, lanes 2 and 7 requesting -> 7 then 2.
    req = 8'h04;
    wait_ack(8'h04, "wrap_lane2");
    req = 8'h84;
    wait_ack(8'h80, "wrap_lane7");
    wait_ack(8'h04, "wrap_back2");
    req = 8'h00;
    repeat (3) step(1'b1);

    // Cancel: lane 3 granted with no data, request withdrawn while waiting.
    req = 8'h08; in_valid = 1'b0;
    en_seen = 0;
    repeat (3) begin
      step(1'b1);
      if (dout_en) en_seen = 1;
    end
    check("cancel_waiting_ready", 32'(in_ready), 32'd1);
    req = 8'h00;
    repeat (3) begin
      step(1'b1);
      if (dout_en) en_seen = 1;
      check("cancel_ack", 32'(ack), 32'd0);
    end
    check("cancel_busy", 32'(busy), 32'd0);
    check("cancel_no_en", 32'(en_seen), 32'd0);
    req = 8'hFF; in_valid = 1'b1;
    wait_ack(8'h08, "cancel_rescan_lane3");
    req = 8'h00;
    repeat (2) step(1'b1);

    // No requests: a valid source word is never accepted.
    in_valid = 1'b1;
    for (int n = 0; n < 20; n++) begin
      step(1'b1);
      check("noreq_in_ready", 32'(in_ready), 32'd0);
      check("noreq_dout_en",  32'(dout_en),  32'd0);
      check("noreq_ack",      32'(ack),      32'd0);
    end

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0)
        req = ($urandom_range(0, 1) == 0) ? (8'h01 << $urandom_range(0, 7)) : 8'($urandom);
      in_valid = ($urandom_range(0, 2) == 0);
      in_data = 1'($urandom);
      step(1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/demux_scheduler.md
Name: demux_scheduler

Overview:
- Round-robin scheduler that shares one serial data source among 8 consumer lanes by sequencing the 1-to-8 demux select lines.
- Lanes raise requests. The block grants one lane, accepts one input word by valid/ready, drives sel/dout to the demux for a fixed hold window, then acknowledges the lane.
- Sits between the data source and the existing 1-to-8 demux. The demux itself is unchanged.

Parameters:
- DATA_W, 1, width of in_data/dout (1 matches the existing demux din).
- HOLD_CYCLES, 3, cycles dout_en/sel/dout are held per transfer; must be >= 1 (elaboration-time check).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- req  input  8  per-lane request, level; bit i = lane i.
- in_valid  input  1  source word valid.
- in_data  input  DATA_W  source word.
- in_ready  output  1  scheduler accepts word; transfer when in_valid & in_ready.
- sel  output  3  binary lane index to demux; sel[2]->s0, sel[1]->s1, sel[0]->s2 (demux output index = s0*4+s1*2+s2).
- dout  output  DATA_W  data to demux din.
- dout_en  output  1  high while dout is being delivered to lane sel.
- ack  output  8  one-hot, one-cycle completion pulse to granted lane.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; sel=0, dout=0, dout_en=0, ack=0, in_ready=0, busy=0.
  - last-grant pointer ptr=7, so lane 0 has first priority.
  - Applies immediately, including mid-transfer; an in-flight transfer gets no ack.
- All outputs are registered or decoded from registered state only; no combinational input-to-output paths.
- States: IDLE, WAIT_DATA, HOLD, ACK.
- IDLE:
  - If req != 0, grant the first requesting lane scanning ptr+1, ptr+2, ... modulo 8; register the grant index; go to WAIT_DATA.
  - Otherwise stay in IDLE.
- WAIT_DATA:
  - in_ready=1, busy=1.
  - On in_valid=1: capture in_data into dout, set sel=grant, dout_en=1, load counter=HOLD_CYCLES-1, go to HOLD.
  - Else if req[grant]=0: cancel. Return to IDLE, no ack, ptr unchanged.
  - If in_valid and req[grant] drop in the same cycle, the handshake wins.
- HOLD:
  - dout_en=1; sel and dout stable; in_ready=0.
  - Decrement counter; when counter==0 go to ACK.
  - dout_en is high for exactly HOLD_CYCLES cycles.
  - Changes on req are ignored during HOLD.
- ACK:
  - ack[grant]=1 for exactly one cycle; dout_en=0, dout=0 (all demux outputs return to 0).
  - sel retains its last value; ptr=grant; go to IDLE.
- Timing (cycle k = interval after edge k; req and in_valid high before edge 1):
  - edge 1: IDLE->WAIT_DATA.
  - edge 2: handshake; dout_en high in cycles 2..1+HOLD_CYCLES.
  - ack high in cycle 2+HOLD_CYCLES.
  - IDLE in cycle 3+HOLD_CYCLES.
- Minimum transfer period is HOLD_CYCLES+3 cycles (6 at default).
- in_valid with no grant is ignored; in_ready stays 0 and the source must hold its word.
- ptr wraps 7->0. A lane deasserting req while not granted is simply skipped.

Decomposition:
- Package demux_sched_pkg holds:
  - LANES=8 and SEL_W=3.
  - state enum {IDLE, WAIT_DATA, HOLD, ACK}.
  - HOLD counter width rule: $clog2(HOLD_CYCLES+1).
- One natural sub-module: rr_arbiter8. Purely combinational: req[7:0], ptr[2:0] -> gnt_idx[2:0], gnt_valid.
- The demux is instantiated alongside this block at integration level, not inside it.

Test Plan:
- Single lane: req=8'b0010_0000, in_valid=1, in_data=1, HOLD=3 -> sel=5 and dout_en=1 in cycles 2-4; demux d5=1, all other d outputs 0; ack=8'b0010_0000 in cycle 5 only; busy=0 in cycle 6.
- Fairness: req=8'hFF held, in_valid=1 continuously -> grant order 0,1,2,...,7,0; one ack every 6 cycles; no lane granted twice within 8 transfers.
- Pointer wrap: after a lane-2 grant, req=8'b1000_0100 -> next grant lane 7, then lane 2.
- Cancel: req[3]=1, in_valid=0, then req[3] dropped during WAIT_DATA -> return to IDLE, ack stays 0, dout_en never asserted, next grant still starts scan at lane 3.
- Reset mid-op: rst_n=0 asynchronously during HOLD -> dout_en, dout, sel, ack, busy go to 0 immediately with no ack. After release with req=8'hFF, first grant is lane 0.
- No request: in_valid=1, req=0 for 20 cycles -> in_ready=0, dout_en=0, ack=0 throughout.
